// File: rtl/idma_reg64_1d_launch_pkg.sv
// rtl/idma_reg64_1d_launch_pkg.sv - shared widths, types and request payload for the launch stage
package idma_reg64_1d_launch_pkg;

   localparam int unsigned NumStreams     = 16;
   localparam int unsigned AddrWidth      = 64;
   localparam int unsigned ConfWidth      = 32;
   localparam int unsigned IdWidth        = 32;
   localparam int unsigned MaxOutstanding = 8;

   function automatic int unsigned stream_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned StreamWidth = stream_width(NumStreams);
   localparam int unsigned CntWidth    = $clog2(MaxOutstanding + 1);

   typedef logic [IdWidth-1:0]     id_t;
   typedef logic [AddrWidth-1:0]   addr_t;
   typedef logic [ConfWidth-1:0]   conf_t;
   typedef logic [StreamWidth-1:0] stream_t;
   typedef logic [CntWidth-1:0]    cnt_t;

   typedef struct packed {
      addr_t   dst;
      addr_t   src;
      addr_t   length;
      conf_t   conf;
      stream_t stream;
      id_t     id;
   } req_t;

endpackage

// File: rtl/idma_reg64_1d_launch_if.sv
// rtl/idma_reg64_1d_launch_if.sv - backend request/response handshake bundle
interface idma_reg64_1d_launch_if;
   import idma_reg64_1d_launch_pkg::*;

   logic    req_valid;
   logic    req_ready;
   req_t    req;
   logic    rsp_valid;
   stream_t rsp_stream;

   modport master (
      output req_valid, req,
      input  req_ready, rsp_valid, rsp_stream
   );

   modport slave (
      input  req_valid, req,
      output req_ready, rsp_valid, rsp_stream
   );

endinterface

// File: rtl/idma_stream_id_tracker.sv
// rtl/idma_stream_id_tracker.sv - per-stream issue/done ID counters and outstanding count
module idma_stream_id_tracker
   import idma_reg64_1d_launch_pkg::*;
(
   input  logic clk_i,
   input  logic rst_ni,
   input  logic launch_i,
   input  logic rsp_i,
   output id_t  next_id_o,
   output id_t  done_id_o,
   output logic full_o,
   output logic busy_o,
   output logic unexpected_o
);

   id_t  nid;
   id_t  did;
   cnt_t out_cnt;
   logic dec;

   // A completion with nothing outstanding is dropped and only flagged.
   assign dec = rsp_i && (out_cnt != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         nid          <= '0;
         did          <= '0;
         out_cnt      <= '0;
         unexpected_o <= 1'b0;
      end else begin
         if (launch_i) nid <= nid + id_t'(1);
         if (dec)      did <= did + id_t'(1);
         case ({launch_i, dec})
            2'b10:   out_cnt <= out_cnt + cnt_t'(1);
            2'b01:   out_cnt <= out_cnt - cnt_t'(1);
            default: out_cnt <= out_cnt;
         endcase
         unexpected_o <= rsp_i && (out_cnt == '0);
      end
   end

   assign next_id_o = nid + id_t'(1);
   assign done_id_o = did;
   assign full_o    = (out_cnt == cnt_t'(MaxOutstanding));
   assign busy_o    = (out_cnt != '0);

endmodule

// File: rtl/idma_reg64_1d_launch.sv
// rtl/idma_reg64_1d_launch.sv - NEXT_ID launch, stall and one-entry backend request buffer
module idma_reg64_1d_launch
   import idma_reg64_1d_launch_pkg::*;
(
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          launch_i,
   input  stream_t                       launch_stream_i,
   input  addr_t                         dst_addr_i,
   input  addr_t                         src_addr_i,
   input  addr_t                         length_i,
   input  conf_t                         conf_i,
   output logic                          launch_stall_o,
   output id_t                           next_id_o,
   idma_reg64_1d_launch_if.master        backend,
   output logic [NumStreams*IdWidth-1:0] done_id_o,
   output logic [NumStreams-1:0]         busy_o,
   output logic                          rsp_unexpected_o
);

   id_t                  next_id_w [NumStreams];
   logic [NumStreams-1:0] full_w;
   logic [NumStreams-1:0] unexp_w;
   logic                 buf_full;
   logic                 accept;

   // The buffer frees up in the same cycle it drains, so only a blocked drain stalls.
   assign launch_stall_o = launch_i &
                           ((buf_full & ~backend.req_ready) | full_w[launch_stream_i]);
   assign accept         = launch_i & ~launch_stall_o;
   assign next_id_o      = accept ? next_id_w[launch_stream_i] : '0;

   for (genvar s = 0; s < NumStreams; s++) begin : g_trk
      idma_stream_id_tracker u_trk (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .launch_i     (accept && (launch_stream_i == stream_t'(s))),
         .rsp_i        (backend.rsp_valid && (backend.rsp_stream == stream_t'(s))),
         .next_id_o    (next_id_w[s]),
         .done_id_o    (done_id_o[s*IdWidth +: IdWidth]),
         .full_o       (full_w[s]),
         .busy_o       (busy_o[s]),
         .unexpected_o (unexp_w[s])
      );
   end

   assign rsp_unexpected_o = |unexp_w;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         buf_full    <= 1'b0;
         backend.req <= '0;
      end else if (accept) begin
         buf_full    <= 1'b1;
         backend.req <= '{dst:    dst_addr_i,
                          src:    src_addr_i,
                          length: length_i,
                          conf:   conf_i,
                          stream: launch_stream_i,
                          id:     next_id_w[launch_stream_i]};
      end else if (backend.req_ready) begin
         buf_full    <= 1'b0;
      end
   end

   assign backend.req_valid = buf_full;

endmodule

// File: doc/idma_reg64_1d_launch.md
Name: idma_reg64_1d_launch

Overview:
Transfer-launch and ID-tracking stage between the 64-bit 1D register file and the iDMA backend request/response ports. A software read of NEXT_ID_k launches one transfer on stream k: the stage snapshots DST_ADDR, SRC_ADDR, LENGTH and CONF, allocates a per-stream transfer ID and returns that ID as read data. It then presents the request to the backend through a one-entry valid/ready buffer. It counts backend completions per stream to drive the DONE_ID_k and STATUS_k read values.

Parameters:
NumStreams, 16, number of independent streams (NEXT_ID/DONE_ID/STATUS register count)
AddrWidth, 64, width of src/dst address and length
ConfWidth, 32, width of the CONF register snapshot
IdWidth, 32, width of transfer IDs
MaxOutstanding, 8, maximum issued-but-not-completed transfers per stream
StreamWidth, derived $clog2(NumStreams), stream index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
launch_i  in  1  one-cycle pulse: register-file read of NEXT_ID_k
launch_stream_i  in  StreamWidth  k of the NEXT_ID_k read
dst_addr_i  in  AddrWidth  current DST_ADDR_1:0 value
src_addr_i  in  AddrWidth  current SRC_ADDR_1:0 value
length_i  in  AddrWidth  current LENGTH_1:0 value
conf_i  in  ConfWidth  current CONF value
launch_stall_o  out  1  launch cannot be accepted this cycle; register file holds the read
next_id_o  out  IdWidth  read data for the NEXT_ID_k read (valid when launch_i & !launch_stall_o)
req_valid_o  out  1  backend request valid
req_ready_i  in  1  backend request ready
req_dst_addr_o / req_src_addr_o / req_length_o  out  AddrWidth  buffered request fields
req_conf_o  out  ConfWidth  buffered CONF snapshot
req_stream_o  out  StreamWidth  buffered stream index
req_id_o  out  IdWidth  buffered transfer ID
rsp_valid_i  in  1  backend completion pulse, in issue order per stream
rsp_stream_i  in  StreamWidth  stream of the completion
done_id_o  out  NumStreams*IdWidth  DONE_ID_k, packed, stream 0 in LSBs
busy_o  out  NumStreams  STATUS_k busy bit: outstanding count of stream k is nonzero
rsp_unexpected_o  out  1  one-cycle flag: completion received on a stream with zero outstanding

Behaviour:
- Reset: all next/done counters 0, outstanding counts 0, buffer empty. req_valid_o=0, req_* fields=0, busy_o=0, done_id_o=0, rsp_unexpected_o=0. Reset mid-transfer discards the buffered request and does not wait for the backend.
- Per stream k: issue counter nid_k, done counter did_k, outstanding count out_k (width $clog2(MaxOutstanding+1)).
- launch_stall_o = launch_i & ((buf_full & !req_ready_i) | out_k == MaxOutstanding), with k = launch_stream_i. It is combinational and depends only on launch_i, launch_stream_i, req_ready_i and state.
- Accepted launch (launch_i & !launch_stall_o):
  - next_id_o = nid_k + 1, combinational in the same cycle.
  - nid_k <= nid_k + 1 and out_k increments.
  - Buffer loads {dst, src, length, conf, k, nid_k+1}; req_valid_o=1 from the next cycle (latency 1).
  - When no launch is accepted, next_id_o = 0.
- Buffer: one entry. It accepts a load in the same cycle as a drain (req_valid_o & req_ready_i), giving back-to-back throughput of 1 request/cycle. The payload is stable while req_valid_o=1 and !req_ready_i.
- Completion (rsp_valid_i on stream j):
  - If out_j > 0: did_j <= did_j + 1 and out_j decrements.
  - If out_j == 0: counters are unchanged and rsp_unexpected_o pulses the next cycle.
- Same-cycle launch and completion on the same stream: out_k unchanged, both counters advance.
- Counters wrap modulo 2^IdWidth (0xFFFFFFFF -> 0). ID 0 is only reported as done after wrap.
- Zero-length transfers are forwarded like any other; this stage does not special-case them.
- busy_o[k] = (out_k != 0), registered view of the counts. done_id_o[k] = did_k.

Decomposition:
- Shared package idma_reg64_1d_launch_pkg: request struct typedef {dst, src, length, conf, stream, id}, the id_t typedef and the StreamWidth function.
- Sub-module idma_stream_id_tracker: one per stream (generate loop), holding nid/did/out counters, the inc/dec/wrap logic and the full/unexpected flags.
- Top level: stream decode, stall logic and the one-entry request buffer.

Test Plan:
- Reset, then launch on stream 3 with dst=0x1000, src=0x2000, len=0x40, req_ready_i=1 -> next_id_o=1 same cycle; the next cycle carries req_valid_o=1, req_id_o=1 and req_stream_o=3; busy_o[3]=1.
- Hold req_ready_i=0, launch stream 0 twice in consecutive cycles -> first accepted (id 1), second gets launch_stall_o=1 until req_ready_i=1, then is accepted with id 2; payload of id 1 is stable throughout the stall.
- 8 launches on stream 5 with no completions -> 9th launch stalls. One rsp_valid_i on stream 5 -> done_id[5]=1 and the 9th launch is accepted with id 9.
- Force nid_2=0xFFFFFFFF via a preceding launch sequence, launch stream 2 -> next_id_o=0; the matching completion sets done_id[2]=0.
- Same-cycle launch and completion on stream 7 with out_7=1 -> out_7 stays 1, busy_o[7]=1, done_id[7] increments.
- rsp_valid_i on idle stream 9 -> rsp_unexpected_o pulses once and done_id[9] stays 0. Separately, assert rst_ni low while req_valid_o=1 -> req_valid_o=0 and all counters 0 immediately.
